// File: rtl/prim_reqack_src_buf.sv
// rtl/prim_reqack_src_buf.sv - valid/ready to req/ack source buffer with FIFO, timeout and error flags
//
// Purpose: buffers an upstream valid/ready stream in a small FIFO and presents
// it to a req/ack CDC synchroniser source port, one word per handshake, with
// the payload held stable while req_o is high.
//
// Ports:
//   clk_i       clock (synchroniser source clock)
//   rst_i       synchronous active-high reset
//   in_valid_i  upstream valid
//   in_ready_o  FIFO not full
//   in_data_i   upstream payload
//   req_o       level request to synchroniser
//   ack_i       single-cycle ack from synchroniser
//   data_o      registered payload for the crossing
//   level_o     FIFO occupancy
//   timeout_o   sticky: handshake exceeded TimeoutCycles
//   err_ack_o   sticky: ack seen while not requesting
//   clr_i       clears the sticky flags
module prim_reqack_src_buf #(
  parameter int unsigned Width         = 8,
  parameter int unsigned Depth         = 2,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [Width-1:0]             in_data_i,
  output logic                         req_o,
  input  logic                         ack_i,
  output logic [Width-1:0]             data_o,
  output logic [$clog2(Depth+1)-1:0]   level_o,
  output logic                         timeout_o,
  output logic                         err_ack_o,
  input  logic                         clr_i
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned LvlW = $clog2(Depth+1);
  localparam int unsigned TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles+1) : 1;
  // Count value that, after one more idle REQ cycle, reaches TimeoutCycles.
  localparam int unsigned TmoLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [Width-1:0]    r_mem [Depth];
  logic [PtrW-1:0]     r_wptr;
  logic [PtrW-1:0]     r_rptr;
  logic [LvlW-1:0]     r_level;
  logic [Width-1:0]    r_data;
  logic [Width-1:0]    w_data_nxt;
  logic [TmoW-1:0]     r_tmo_cnt;
  logic [TmoW-1:0]     w_tmo_cnt_nxt;
  logic                r_timeout;
  logic                r_err_ack;
  logic                w_push;
  logic                w_pop;
  logic                w_tmo_set;
  logic                w_err_set;
  logic [PtrW-1:0]     w_wptr_inc;
  logic [PtrW-1:0]     w_rptr_inc;

  assign in_ready_o = (r_level != LvlW'(Depth));
  assign w_push     = in_valid_i & in_ready_o;
  // An ack outside REQ is only flagged; it never pops.
  assign w_pop      = (r_state == REQ) & ack_i;
  assign w_err_set  = (r_state == IDLE) & ack_i;

  assign w_wptr_inc = (r_wptr == PtrW'(Depth-1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_inc = (r_rptr == PtrW'(Depth-1)) ? '0 : r_rptr + 1'b1;

  // Set only on the edge where the count reaches TimeoutCycles, so a clear
  // issued while the counter sits saturated actually takes effect.
  assign w_tmo_set = (TimeoutCycles != 0) && (r_state == REQ) && !ack_i &&
                     (r_tmo_cnt == TmoW'(TmoLast));

  always_comb begin
    w_state_nxt   = r_state;
    w_data_nxt    = r_data;
    w_tmo_cnt_nxt = '0;
    case (r_state)
      IDLE: begin
        if (r_level != '0) begin
          w_state_nxt = REQ;
          w_data_nxt  = r_mem[r_rptr];
        end
      end
      REQ: begin
        if (ack_i) begin
          // Post-pop occupancy excludes a same-cycle push on purpose: that
          // word is picked up through IDLE on the next cycle.
          if (r_level > LvlW'(1)) begin
            w_data_nxt = r_mem[w_rptr_inc];
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (TimeoutCycles != 0) begin
          if (r_tmo_cnt != TmoW'(TimeoutCycles)) begin
            w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
          end else begin
            w_tmo_cnt_nxt = r_tmo_cnt;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_data    <= '0;
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
      r_err_ack <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_data    <= w_data_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
      if (w_push) begin
        r_wptr <= w_wptr_inc;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_inc;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_tmo_set) begin
        r_timeout <= 1'b1;
      end else if (clr_i) begin
        r_timeout <= 1'b0;
      end
      if (w_err_set) begin
        r_err_ack <= 1'b1;
      end else if (clr_i) begin
        r_err_ack <= 1'b0;
      end
    end
  end

  assign req_o     = (r_state == REQ);
  assign data_o    = r_data;
  assign level_o   = r_level;
  assign timeout_o = r_timeout;
  assign err_ack_o = r_err_ack;

endmodule
